div_operand_fifo: RTL

- Upstream issue stage for the combinational DIV datapath component.
- Accepts operand pairs (dividend, divisor) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Screens divide-by-zero on entry.
- Presents the head pair on a/b outputs that wire directly to DIV's a/b inputs, with its own valid/ready handshake toward the consumer of quot.

---
 rtl/div_operand_fifo.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_operand_fifo.sv
// ---------------------------------------------------------------------------
// div_operand_fifo
//
// Issue stage in front of the combinational DIV datapath. Operand pairs
// (dividend, divisor) come in over a valid/ready handshake and are held in a
// DEPTH-entry FIFO. The head pair drives DIV's a/b inputs directly. A
// divide-by-zero request is caught as it enters the FIFO: it is stored as
// a=0, b=1 with dz=1, so DIV yields quot=0 instead of an undefined result.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        asynchronous reset, active-low
//   in_valid   upstream offers in_a/in_b this cycle
//   in_ready   FIFO can accept (not full)
//   in_a/in_b  incoming dividend / divisor
//   out_valid  head entry present (not empty)
//   out_ready  consumer takes the head pair this cycle
//   a/b        head dividend / divisor to DIV (0/0 when empty)
//   dz         head entry was a divide-by-zero request
//   count      current occupancy, 0..DEPTH
//   dz_count   saturating count of accepted b==0 requests
// ---------------------------------------------------------------------------
module div_operand_fifo #(
  parameter int DATAWIDTH = 8,
  parameter int DEPTH     = 4,
  parameter int CNTWIDTH  = 8
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATAWIDTH-1:0]       in_a,
  input  logic [DATAWIDTH-1:0]       in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATAWIDTH-1:0]       a,
  output logic [DATAWIDTH-1:0]       b,
  output logic                       dz,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNTWIDTH-1:0]        dz_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Storage is kept in flops: the head must be readable in the same cycle
  // and every entry is cleared by reset.
  logic [DATAWIDTH-1:0] mem_a  [DEPTH];
  logic [DATAWIDTH-1:0] mem_b  [DEPTH];
  logic                 mem_dz [DEPTH];

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        occ;

  logic                 push;
  logic                 pop;
  logic                 in_dz;
  logic [DATAWIDTH-1:0] store_a;
  logic [DATAWIDTH-1:0] store_b;

  // Handshake flags depend on registered occupancy only, so there is no
  // combinational path from out_ready to in_ready: a full FIFO that is
  // popped this cycle still refuses the push until the next cycle.
  assign in_ready  = (occ != FULL_COUNT);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Divide-by-zero screening: substitute 0/1 so DIV produces quot=0.
  assign in_dz   = (in_b == '0);
  assign store_a = in_dz ? '0 : in_a;
  assign store_b = in_dz ? DATAWIDTH'(1) : in_b;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i]  <= '0;
        mem_b[i]  <= '0;
        mem_dz[i] <= 1'b0;
      end
    end else if (push) begin
      mem_a[wr_ptr]  <= store_a;
      mem_b[wr_ptr]  <= store_b;
      mem_dz[wr_ptr] <= in_dz;
    end
  end

  // DEPTH is a power of two, so plain pointer increment wraps mod DEPTH.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      dz_count <= '0;
    end else if (push && in_dz && (dz_count != '1)) begin
      dz_count <= dz_count + 1'b1;
    end
  end

  // Head presentation: zeroes while empty so DIV never sees stale operands.
  always_comb begin
    a  = '0;
    b  = '0;
    dz = 1'b0;
    if (out_valid) begin
      a  = mem_a[rd_ptr];
      b  = mem_b[rd_ptr];
      dz = mem_dz[rd_ptr];
    end
  end

  assign count = occ;

endmodule
